// File: rtl/alu_issue_queue.sv
// alu_issue_queue: FIFO-buffered issue stage in front of the clocked ALU.
// One op in flight at a time; the result is held on a valid/ready port.
module alu_issue_queue #(
    parameter int DW      = 40,
    parameter int SW      = 5,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [SW-1:0] in_s,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [SW-1:0] alu_s,
    input  logic [DW-1:0] alu_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic [SW-1:0] res_op,
    output logic          busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam int EW = 2 * DW + SW;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
    logic [SW-1:0]   op_q, op_d;
    logic [DW-1:0]   alu_a_q, alu_a_d;
    logic [DW-1:0]   alu_b_q, alu_b_d;
    logic [SW-1:0]   alu_s_q, alu_s_d;
    logic            res_valid_q, res_valid_d;
    logic [DW-1:0]   res_data_q, res_data_d;
    logic [SW-1:0]   res_op_q, res_op_d;
    logic            push;
    logic            pop;
    logic            issue;
    logic [EW-1:0]   head;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign push      = in_valid & in_ready;
    assign pop       = issue;
    assign head      = mem_q[rd_ptr_q];
    assign busy      = (count_q != '0) | (state_q != S_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;

    // FIFO storage: entries are {s, a, b}; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_s, in_a, in_b};
        end
    end

    // Pointer and occupancy update; push+pop leaves count unchanged
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Issue/wait/hold sequencing; issue decisions use registered count only
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        op_d        = op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_s_d     = alu_s_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        issue       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                issue = (count_q != '0);
            end
            S_WAIT: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - LW'(1);
                end else begin
                    res_data_d  = alu_out;
                    res_op_d    = op_q;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (count_q != '0) begin
                        issue = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (issue) begin
            alu_s_d   = head[EW-1 -: SW];
            alu_a_d   = head[2*DW-1 -: DW];
            alu_b_d   = head[DW-1:0];
            op_d      = head[EW-1 -: SW];
            lat_cnt_d = LW'(ALU_LAT);
            state_d   = S_WAIT;
        end
    end

    // State registers; reset drops queued, in-flight and held work
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lat_cnt_q   <= '0;
            op_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lat_cnt_q   <= lat_cnt_d;
            op_q        <= op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_s_q     <= alu_s_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: vectors, directed corner sequences and random
// traffic against a queue-based result model.
module tb_alu_issue_queue;

    localparam int DW = 40;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, res_valid, res_ready, busy;
    logic [DW-1:0] in_a, in_b, alu_a, alu_b, alu_out, res_data;
    logic [SW-1:0] in_s, alu_s, res_op;

    logic          iv3, ir3, rv3, rr3, busy3;
    logic [DW-1:0] a3, b3, alu_a3, alu_b3, alu_out3, rd3, p1, p2;
    logic [SW-1:0] s3, alu_s3, rop3;

    always #5 clk = ~clk;

    alu_issue_queue #(.DW(DW), .SW(SW), .DEPTH(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_s(in_s),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .busy(busy)
    );

    alu_issue_queue #(.DW(DW), .SW(SW), .DEPTH(4), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv3), .in_ready(ir3),
        .in_a(a3), .in_b(b3), .in_s(s3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_s(alu_s3),
        .alu_out(alu_out3),
        .res_valid(rv3), .res_ready(rr3),
        .res_data(rd3), .res_op(rop3), .busy(busy3)
    );

    // ALU stubs: 1-stage and 3-stage adders
    always_ff @(posedge clk) alu_out <= alu_a + alu_b;
    always_ff @(posedge clk) begin
        p1       <= alu_a3 + alu_b3;
        p2       <= p1;
        alu_out3 <= p2;
    end

    typedef struct {
        logic [SW-1:0] op;
        logic [DW-1:0] d;
    } res_t;

    typedef struct {
        bit            iv;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [SW-1:0] s;
        bit            rr;
        bit            e_ir;
        logic [DW-1:0] e_alu_a;
        logic [SW-1:0] e_alu_s;
        bit            e_rv;
        logic [DW-1:0] e_rd;
        logic [SW-1:0] e_rop;
        bit            e_busy;
    } vec_t;

    res_t exp_q[$];
    int   hs_cyc[$];
    int   cyc;
    int   errors;
    int   checks;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard step: account for handshakes at the coming edge
    task automatic tick();
        res_t r;
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none",
                         res_data);
            end else begin
                r = exp_q.pop_front();
                chk("res_data", 64'(res_data), 64'(r.d));
                chk("res_op", 64'(res_op), 64'(r.op));
            end
            hs_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) begin
            r.op = in_s;
            r.d  = in_a + in_b;
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0;
        iv3 = 1'b0; a3 = '0; b3 = '0; s3 = '0; rr3 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        res_ready = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        hs_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        while ((exp_q.size() > 0 || busy) && n < max) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n < max), 64'(1));
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_alu_a"}, 64'(alu_a), 64'(0));
        chk({tag, "_alu_b"}, 64'(alu_b), 64'(0));
        chk({tag, "_alu_s"}, 64'(alu_s), 64'(0));
        chk({tag, "_rv"}, 64'(res_valid), 64'(0));
        chk({tag, "_rd"}, 64'(res_data), 64'(0));
        chk({tag, "_rop"}, 64'(res_op), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_ir"}, 64'(in_ready), 64'(1));
        chk({tag, "_busy3"}, 64'(busy3), 64'(0));
        chk({tag, "_ir3"}, 64'(ir3), 64'(1));
        chk({tag, "_alu_a3"}, 64'(alu_a3), 64'(0));
    endtask

    vec_t          tbl[6];
    logic [DW-1:0] h_rd, h_a;
    logic [SW-1:0] h_rop, h_s;
    bit            saw_full, acc, prev_hold;
    int            k, n;

    initial begin
        errors = 0; checks = 0; cyc = 0;
        idle_inputs();
        res_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        chk_reset_outputs("rst");
        do_reset();

        // Basic single op then a second op, ALU_LAT = 1
        tbl[0] = '{1, 40'h0b, 40'h03, 5'b00101, 1,
                   1, 40'h00, 5'd0, 0, 40'h0, 5'd0, 1};
        tbl[1] = '{0, 40'h00, 40'h00, 5'd0, 1,
                   1, 40'h0b, 5'b00101, 0, 40'h0, 5'd0, 1};
        tbl[2] = '{0, 40'h00, 40'h00, 5'd0, 1,
                   1, 40'h0b, 5'b00101, 0, 40'h0, 5'd0, 1};
        tbl[3] = '{0, 40'h00, 40'h00, 5'd0, 1,
                   1, 40'h0b, 5'b00101, 1, 40'h0e, 5'b00101, 1};
        tbl[4] = '{0, 40'h00, 40'h00, 5'd0, 1,
                   1, 40'h0b, 5'b00101, 0, 40'h0, 5'd0, 0};
        tbl[5] = '{1, 40'h20, 40'h07, 5'd3, 1,
                   1, 40'h0b, 5'b00101, 0, 40'h0, 5'd0, 1};
        for (int i = 0; i < 6; i++) begin
            in_valid  = tbl[i].iv;
            in_a      = tbl[i].a;
            in_b      = tbl[i].b;
            in_s      = tbl[i].s;
            res_ready = tbl[i].rr;
            tick();
            chk("vec_ir", 64'(in_ready), 64'(tbl[i].e_ir));
            chk("vec_alu_a", 64'(alu_a), 64'(tbl[i].e_alu_a));
            chk("vec_alu_s", 64'(alu_s), 64'(tbl[i].e_alu_s));
            chk("vec_rv", 64'(res_valid), 64'(tbl[i].e_rv));
            if (tbl[i].e_rv) begin
                chk("vec_rd", 64'(res_data), 64'(tbl[i].e_rd));
                chk("vec_rop", 64'(res_op), 64'(tbl[i].e_rop));
            end
            chk("vec_busy", 64'(busy), 64'(tbl[i].e_busy));
        end
        drain(40);

        // Fill: five pushes with consumer stalled, sixth refused
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a = DW'(100 + i); in_b = DW'(i); in_s = SW'(i + 1);
            tick();
        end
        chk("fill_full_ir", 64'(in_ready), 64'(0));
        in_a = DW'(999); in_b = '0; in_s = 5'd31;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fill_sixth_ir", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;

        // Hold: result and ALU drive frozen while stalled
        chk("hold_rv0", 64'(res_valid), 64'(1));
        h_rd = res_data; h_rop = res_op; h_a = alu_a; h_s = alu_s;
        chk("hold_first", 64'(res_data), 64'(100));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_rv", 64'(res_valid), 64'(1));
            chk("hold_rd", 64'(res_data), 64'(h_rd));
            chk("hold_rop", 64'(res_op), 64'(h_rop));
            chk("hold_alu_a", 64'(alu_a), 64'(h_a));
            chk("hold_alu_s", 64'(alu_s), 64'(h_s));
        end
        hs_cyc.delete();
        drain(60);
        chk("fill_results", 64'(hs_cyc.size()), 64'(5));
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("fill_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(3));

        // Wrap: 12 ops a=1..12, b=0, through three pointer wraps
        do_reset();
        saw_full = 1'b0;
        k = 1;
        n = 0;
        res_ready = 1'b1;
        while ((k <= 12 || exp_q.size() > 0 || busy) && n < 200) begin
            in_valid = (k <= 12);
            in_a = DW'(k); in_b = '0; in_s = SW'(k);
            if (!in_ready) saw_full = 1'b1;
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
            n++;
        end
        chk("wrap_timeout", 64'(n < 200), 64'(1));
        chk("wrap_results", 64'(hs_cyc.size()), 64'(12));
        chk("wrap_saw_full", 64'(saw_full), 64'(1));

        // Latency parameter: ALU_LAT = 3 with a 3-stage stub
        do_reset();
        iv3 = 1'b1; a3 = 40'h123456789a; b3 = 40'h1; s3 = 5'd9; rr3 = 1'b1;
        tick();
        iv3 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("lat3_rv", 64'(rv3), 64'(i == 5));
        end
        chk("lat3_rd", 64'(rd3), 64'h123456789b);
        chk("lat3_rop", 64'(rop3), 64'(9));

        // Reset mid-op: one in WAIT, two queued
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = DW'(50 + i); in_b = DW'(7); in_s = SW'(20 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_busy", 64'(busy), 64'(1));
        chk("mid_alu_a", 64'(alu_a), 64'(50));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_rv", 64'(res_valid), 64'(0));
            chk("post_rst_busy", 64'(busy), 64'(0));
        end
        hs_cyc.delete();
        in_valid = 1'b1; in_a = 40'hff00000001; in_b = 40'h2; in_s = 5'd17;
        tick();
        drain(40);
        chk("post_rst_results", 64'(hs_cyc.size()), 64'(1));

        // Random traffic against the queue model
        do_reset();
        prev_hold = 1'b0;
        h_rd = '0;
        for (int i = 0; i < 400; i++) begin
            if (prev_hold) begin
                chk("rnd_hold_rv", 64'(res_valid), 64'(1));
                chk("rnd_hold_rd", 64'(res_data), 64'(h_rd));
            end
            in_valid  = ($urandom_range(0, 1) == 1);
            in_a      = DW'({$urandom(), $urandom()});
            in_b      = DW'({$urandom(), $urandom()});
            in_s      = SW'($urandom());
            res_ready = ($urandom_range(0, 3) != 0);
            prev_hold = res_valid && !res_ready;
            h_rd      = res_data;
            tick();
        end
        drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Operand/opcode issue stage placed directly upstream of the 40-bit clocked ALU. It buffers incoming `{s, a, b}` operations in a small FIFO and drives them one at a time onto the ALU's `a`, `b` and `s` inputs. After a fixed ALU latency it captures the ALU result and presents it on a valid/ready result port together with the opcode that produced it. Only one operation is in flight at a time, so results leave in issue order.

## Interface
- `DW`, 40: operand and result width; matches ALU `a`/`b`/`out`.
- `SW`, 5: opcode width; matches ALU `s`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ALU_LAT`, 1: edges between the ALU sampling its inputs and `out` being valid to sample.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `in_valid`  in  1  an operation is offered.
- `in_ready`  out  1  FIFO can accept an operation.
- `in_a`, `in_b`  in  DW  operands.
- `in_s`  in  SW  opcode.
- `alu_a`, `alu_b`  out  DW  registered; connect to ALU `a`, `b`.
- `alu_s`  out  SW  registered; connect to ALU `s`.
- `alu_out`  in  DW  ALU `out`.
- `res_valid`  out  1  `res_data` and `res_op` are valid.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  DW  captured ALU result.
- `res_op`  out  SW  opcode of the captured result.
- `busy`  out  1  high when FIFO is non-empty or state ≠ IDLE.

## Operation
- **FIFO push**
  - Push on `in_valid & in_ready`.
  - `in_ready = (count < DEPTH)`. It is a function of `count` only, with no combinational path from pop.
  - When full, `in_valid` is ignored and the data is not stored.
- **Pointers**
  - Read and write pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`.
  - A simultaneous push and pop leaves `count` unchanged.
- **FSM states: IDLE, WAIT, HOLD**
  - **IDLE**, `count>0`: load `alu_a/b/s` from the FIFO head, pop, stash `op_q` = head opcode, load `lat_cnt = ALU_LAT`, go to WAIT.
  - **WAIT**:
    - If `lat_cnt != 0`, decrement it.
    - Else capture `res_data = alu_out`, `res_op = op_q`, set `res_valid = 1`, go to HOLD.
  - **HOLD**: `res_valid` stays high and `res_data/res_op` stay stable until `res_ready`. On the `res_ready` edge:
    - FIFO non-empty: clear `res_valid` and issue the next head, exactly as from IDLE, going to WAIT.
    - FIFO empty: clear `res_valid`, go to IDLE.
- **Between issues**
  - `alu_a/b/s` hold their last issued values.
  - The ALU is never driven with an unpopped entry.
- **Push into an empty FIFO** is not issued on the same edge. The entry becomes visible via `count` and is issued on the following edge.
- **Reset**
  - Outputs while `rst_n` is low: `alu_a = alu_b = 0`, `alu_s = 0`, `res_valid = 0`, `res_data = 0`, `res_op = 0`, `busy = 0`, `in_ready = 1`.
  - Internal state while `rst_n` is low: `count = 0`, pointers = 0, state = IDLE.
  - Reset asserted mid-operation discards the FIFO contents, the in-flight operation and any held result. Nothing is replayed after reset.

## Timing
- Issue edge E: `alu_*` are updated at E.
  - ALU samples them at E+1.
  - Result is captured at E+1+`ALU_LAT`.
  - `res_valid` is high from then on (E+2 for the default).
- Push at edge P into an idle, empty block gives the issue edge E = P+1. The first `res_valid` is seen after P+3 with `ALU_LAT = 1`.
- Back-to-back throughput with `res_ready` held high: one result per `ALU_LAT+2` cycles.
- `res_valid` and `res_data` are registered. `in_ready` and `busy` are combinational from registered state only.

## Test plan
- **Basic (stub ALU):** bench uses a registered ALU stub with `out = a + b`, 1-cycle latency. Reset, then push `a=0x000000000b`, `b=0x0000000003`, `s=5'b00101` with `res_ready=1`.
  - `alu_a=0x0b`, `alu_s=5'b00101` after P+1.
  - `res_valid` high after P+3 with `res_data=0x000000000e`, `res_op=5'b00101`.
- **Fill:** push 5 ops back-to-back with `res_ready=0`.
  - 1st issues, next 4 fill the FIFO.
  - `in_ready` goes low after `count = 4`; a 6th offer is not accepted.
  - Raise `res_ready`: results emerge in push order, one per 3 cycles.
- **Hold:** with `res_ready=0` for 10 cycles, `res_valid`, `res_data` and `res_op` stay constant and no new issue occurs (`alu_*` unchanged).
- **Wrap:** stream 12 ops with distinct `a = 1..12`, `b = 0`, `res_ready=1`.
  - Results are 1..12 in order across 3 pointer wraps.
  - Simultaneous push/pop while at `count = 4` keeps `in_ready` low.
- **Latency parameter:** with `ALU_LAT = 3` and a 3-stage stub, `res_data` matches the stub and the first `res_valid` is seen after P+5.
- **Reset mid-op:** assert `rst_n=0` during WAIT with 2 queued ops.
  - All outputs return to reset values and `busy=0`.
  - After release, no result appears until a new push.
